lab3_dg_keyscan: RTL

- 4x4 matrix keypad scanner and debouncer for the lab 3 keypad display path.
- Drives one column low at a time, synchronizes the active-low row inputs, and debounces presses and releases.
- Per physical press, emits exactly one single-cycle new_key strobe with a registered row/column snapshot.
- Sits directly upstream of lab3_dg_decoder, which consumes keypress and new_key to produce the hex key value. Clocked from the HSOSC-derived int_osc.

---
 rtl/lab3_dg_keyscan.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/lab3_dg_keyscan.sv
// lab3_dg_keyscan: 4x4 keypad column scanner with press/release debounce.
// Define LAB3_KEY_REPEAT_EN to add auto-repeat strobes while a key is held.
module lab3_dg_keyscan #(
  parameter int SCAN_DIV     = 24000,
  parameter int DEBOUNCE_CNT = 480000,
  parameter int REPEAT_CNT   = 12000000
) (
  input  logic       int_osc,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] cols,
  output logic [7:0] keypress,
  output logic       new_key,
  output logic       busy
);

  localparam logic [1:0] S_SCAN = 2'd0;
  localparam logic [1:0] S_DEB  = 2'd1;
  localparam logic [1:0] S_HELD = 2'd2;
  localparam logic [1:0] S_REL  = 2'd3;

  localparam int SW = $clog2(SCAN_DIV);
  localparam int DW = $clog2(DEBOUNCE_CNT);

  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] SETTLE    = SW'(2);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CNT - 1);

  if (SCAN_DIV < 4 || DEBOUNCE_CNT < 2 || REPEAT_CNT < 2) begin : g_bad_param
    $error("lab3_dg_keyscan: parameter out of range");
  end

  logic [1:0]    state;
  logic [3:0]    rs1;
  logic [3:0]    rs;
  logic [3:0]    cand;
  logic [SW-1:0] scan_cnt;
  logic [DW-1:0] db_cnt;
  logic [3:0]    cols_nx;
  logic          idle;
  logic          match;

`ifdef LAB3_KEY_REPEAT_EN
  localparam int RW = $clog2(REPEAT_CNT + 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CNT - 1);
  logic [RW-1:0] rep_cnt;
  logic          acc;
`endif

  assign cols_nx = {cols[2:0], cols[3]};
  assign idle    = (rs == 4'hF);
  assign match   = (rs == cand);
  assign busy    = (state != S_SCAN);

  always_ff @(posedge int_osc) begin
    if (reset) begin
      rs1 <= 4'hF;
      rs  <= 4'hF;
    end else begin
      rs1 <= row;
      rs  <= rs1;
    end
  end

  always_ff @(posedge int_osc) begin
    if (reset) begin
      state    <= S_SCAN;
      cols     <= 4'b1110;
      scan_cnt <= '0;
      db_cnt   <= '0;
      cand     <= 4'hF;
      keypress <= 8'hFF;
      new_key  <= 1'b0;
`ifdef LAB3_KEY_REPEAT_EN
      rep_cnt  <= '0;
      acc      <= 1'b0;
`endif
    end else begin
      new_key <= 1'b0;
      unique case (state)
        S_SCAN: begin
          // rs still reflects the previous column for two cycles
          if (scan_cnt >= SETTLE && !idle) begin
            cand   <= rs;
            db_cnt <= '0;
            state  <= S_DEB;
          end else if (scan_cnt == SCAN_LAST) begin
            cols     <= cols_nx;
            scan_cnt <= '0;
          end else begin
            scan_cnt <= scan_cnt + SW'(1);
          end
        end
        S_DEB: begin
          if (idle) begin
            state    <= S_SCAN;
            cols     <= cols_nx;
            scan_cnt <= '0;
          end else if (!match) begin
            cand   <= rs;
            db_cnt <= '0;
          end else if (db_cnt == DB_LAST) begin
            if ($onehot(~cand)) begin
              keypress <= {cand, cols};
              new_key  <= 1'b1;
            end
            state <= S_HELD;
`ifdef LAB3_KEY_REPEAT_EN
            acc     <= $onehot(~cand);
            rep_cnt <= '0;
`endif
          end else begin
            db_cnt <= db_cnt + DW'(1);
          end
        end
        S_HELD: begin
          if (idle) begin
            db_cnt <= '0;
            state  <= S_REL;
`ifdef LAB3_KEY_REPEAT_EN
            rep_cnt <= '0;
          end else if (acc && match) begin
            if (rep_cnt == REP_LAST) begin
              rep_cnt <= '0;
              new_key <= 1'b1;
            end else begin
              rep_cnt <= rep_cnt + RW'(1);
            end
`endif
          end
        end
        S_REL: begin
          if (!idle) begin
            state <= S_HELD;
          end else if (db_cnt == DB_LAST) begin
            state    <= S_SCAN;
            cols     <= cols_nx;
            scan_cnt <= '0;
          end else begin
            db_cnt <= db_cnt + DW'(1);
          end
        end
        default: state <= S_SCAN;
      endcase
    end
  end

endmodule
